// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART receiver and its consumer: buffers received bytes,
// reports occupancy, and raises a sticky overrun flag when a byte must be dropped.
module uart_rx_fifo #(
    parameter int D_W    = 8,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [D_W-1:0]    wr_data,
    input  logic              rd_en,
    input  logic              ovr_clr,
    output logic [D_W-1:0]    rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overrun
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   C_DEPTH   = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   C_AF      = AF_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0]   C_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] C_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [D_W-1:0]    r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_almost_full;
    logic              r_overrun;
    logic [D_W-1:0]    r_rd_data;
    logic              r_rd_valid;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_drop;
    logic [ADDR_W:0]   w_count_nxt;

    // Accept/drop decisions from the pre-edge flags; a read frees a slot for a write when full.
    always_comb begin
        w_wr_acc    = wr_en & (~r_full | rd_en);
        w_rd_acc    = rd_en & ~r_empty;
        w_drop      = wr_en & r_full & ~rd_en;
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + C_CNT_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - C_CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Byte storage; contents are not reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // Pointers, occupancy flags, read port and overrun state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr        <= {ADDR_W{1'b0}};
            r_rptr        <= {ADDR_W{1'b0}};
            r_count       <= {(ADDR_W+1){1'b0}};
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overrun     <= 1'b0;
            r_rd_data     <= {D_W{1'b0}};
            r_rd_valid    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + C_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rptr    <= r_rptr + C_PTR_ONE;
                r_rd_data <= r_mem[r_rptr];
            end
            r_rd_valid    <= w_rd_acc;
            r_count       <= w_count_nxt;
            r_empty       <= (w_count_nxt == {(ADDR_W+1){1'b0}});
            r_full        <= (w_count_nxt == C_DEPTH);
            r_almost_full <= (w_count_nxt >= C_AF);
            // A new drop wins over a simultaneous clear so no overrun is lost.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign empty       = r_empty;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign count       = r_count;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic checked against a
// queue-based reference model of the FIFO behaviour.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       ovr_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    byte unsigned q[$];
    logic [7:0]   exp_rd_data;
    logic         exp_rd_valid;
    logic         exp_ovr;

    uart_rx_fifo #(.D_W(8), .ADDR_W(4), .AF_LVL(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .ovr_clr     (ovr_clr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".count"},    32'(count),       32'(q.size()));
        check_eq({tag, ".empty"},    32'(empty),       32'(q.size() == 0));
        check_eq({tag, ".full"},     32'(full),        32'(q.size() == 16));
        check_eq({tag, ".afull"},    32'(almost_full), 32'(q.size() >= 12));
        check_eq({tag, ".overrun"},  32'(overrun),     32'(exp_ovr));
        check_eq({tag, ".rd_valid"}, 32'(rd_valid),    32'(exp_rd_valid));
        check_eq({tag, ".rd_data"},  32'(rd_data),     32'(exp_rd_data));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input string tag, input logic w, input logic [7:0] d,
                        input logic r, input logic c);
        bit wacc;
        bit racc;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        ovr_clr = c;
        @(posedge clk);
        wacc = w && ((q.size() < 16) || r);
        racc = r && (q.size() > 0);
        exp_rd_valid = racc;
        if (racc) exp_rd_data = q.pop_front();
        if (wacc) q.push_back(d);
        if (w && !wacc) exp_ovr = 1'b1;
        else if (c) exp_ovr = 1'b0;
        #1;
        check_all(tag);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        ovr_clr = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        exp_rd_data  = 8'h00;
        exp_rd_valid = 1'b0;
        exp_ovr      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; ovr_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Basic three-byte write then read.
        step("w41", 1'b1, 8'h41, 1'b0, 1'b0);
        step("w42", 1'b1, 8'h42, 1'b0, 1'b0);
        step("w43", 1'b1, 8'h43, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("rd3", 1'b0, 8'h00, 1'b1, 1'b0);
        step("idle", 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("rd3.last", 32'(rd_data), 32'h43);

        // Fill to full, overrun on 17th, drain.
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("w17", 1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
            check_eq("drain.order", 32'(rd_data), 32'(i));
        end
        step("clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous read/write while full.
        for (int i = 0; i < 16; i++) step("fill2", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step("fullrw", 1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("aa.last", 32'(rd_data), 32'hAA);

        // Simultaneous read/write while empty.
        step("emptyrw", 1'b1, 8'h5A, 1'b1, 1'b0);
        step("rd5a", 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("rd5a.data", 32'(rd_data), 32'h5A);

        // Interleaved traffic wrapping the pointers, then overrun and clear.
        for (int i = 0; i < 20; i++) begin
            step("ilv.w", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
            if (i % 2 == 1) step("ilv.r", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        while (q.size() > 0) step("ilv.d", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) step("ovf", 1'b1, 8'(i), 1'b0, 1'b0);
        step("ovf.clrdrop", 1'b1, 8'hEE, 1'b0, 1'b1);
        step("ovf.clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic, alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = ((i / 50) % 2 == 0) ? 75 : 30;
            step("rand", 1'($urandom_range(0, 99) < wp), 8'($urandom),
                 1'($urandom_range(0, 99) < (100 - wp)), 1'($urandom_range(0, 99) < 5));
        end

        // Asynchronous mid-cycle reset with five entries held.
        while (q.size() > 0) step("pre.d", 1'b0, 8'h00, 1'b1, 1'b0);
        step("pre.clr", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("pre.w", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        step("pre.r", 1'b0, 8'h00, 1'b1, 1'b0);
        step("pre.w6", 1'b1, 8'h36, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async");
        #3;
        rst = 1'b0;
        step("post.w", 1'b1, 8'h77, 1'b0, 1'b0);
        step("post.r", 1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("post.data", 32'(rd_data), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter D_W, default 8, meaning data byte width, matching the receiver's data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning log2 of the FIFO depth (DEPTH = 2^ADDR_W = 16).
REQ-003 The block SHALL have parameter AF_LVL, default 12, meaning the almost-full threshold in entries (1..DEPTH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port wr_en, input, 1 bit: one-cycle receive-done strobe from the UART receiver.
REQ-007 The block SHALL have port wr_data, input, D_W bits: received byte, valid when wr_en=1.
REQ-008 The block SHALL have port rd_en, input, 1 bit: consumer read request.
REQ-009 The block SHALL have port ovr_clr, input, 1 bit: clears the sticky overrun flag.
REQ-010 The block SHALL have port rd_data, output, D_W bits: registered read byte.
REQ-011 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking a new rd_data.
REQ-012 The block SHALL have port empty, output, 1 bit: asserted when count = 0.
REQ-013 The block SHALL have port full, output, 1 bit: asserted when count = DEPTH.
REQ-014 The block SHALL have port almost_full, output, 1 bit: asserted when count >= AF_LVL.
REQ-015 The block SHALL have port count, output, ADDR_W+1 bits: the current occupancy, 0..DEPTH.
REQ-016 The block SHALL have port overrun, output, 1 bit: sticky flag set on a dropped byte.

Function
REQ-017 Storage SHALL be a DEPTH x D_W array, indexed by ADDR_W-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-018 A write SHALL be accepted when wr_en=1 and (full=0, or rd_en=1 in the same cycle): store wr_data at wptr, then increment wptr.
REQ-019 A read SHALL be accepted when rd_en=1 and empty=0: load rd_data from mem[rptr] at that edge, increment rptr, and pulse rd_valid high the following cycle only (latency 1).
REQ-020 Read/write decisions SHALL use the pre-edge count; count next = count + write_accepted - read_accepted.
REQ-021 When full, a simultaneous wr_en and rd_en SHALL both succeed, and count SHALL remain DEPTH.
REQ-022 When empty, a simultaneous wr_en and rd_en SHALL accept the write only; the read is ignored, count becomes 1, and no rd_valid pulse occurs.
REQ-023 On wr_en=1 while full=1 and rd_en=0, the byte SHALL be dropped, the contents SHALL be unchanged, and overrun SHALL be set the next cycle.
REQ-024 On rd_en while empty, rd_data SHALL hold its value, rd_valid SHALL stay 0, and the pointers SHALL be unchanged (no underrun flag).
REQ-025 overrun SHALL remain set until ovr_clr=1; if ovr_clr and a new drop coincide, overrun SHALL stay set.
REQ-026 empty, full, almost_full and count SHALL be registered outputs consistent with the post-edge occupancy.

Reset
REQ-027 While rst=1, the block SHALL asynchronously clear wptr, rptr and count to 0, empty to 1, full to 0, almost_full to 0, overrun to 0, rd_valid to 0, and rd_data to 0; storage contents are don't-care.
REQ-028 Asserting rst mid-operation SHALL discard all stored bytes; the first write after release SHALL go to address 0.

Verification
REQ-029 Reset then write 0x41, 0x42, 0x43 -> count=3 and empty=0; three rd_en cycles -> rd_data=0x41, 0x42, 0x43, each with a rd_valid pulse one cycle after its rd_en; finally empty=1.
REQ-030 Write 16 bytes 0x00..0x0F -> almost_full rises at count=12 and full=1 at count=16; a 17th write (0xFF) -> overrun=1, and reading all entries yields 0x00..0x0F with no 0xFF.
REQ-031 When full, drive wr_en=1 (0xAA) and rd_en=1 together -> count stays 16 and overrun stays 0; 0xAA is read out last.
REQ-032 When empty, drive wr_en=1 (0x5A) and rd_en=1 together -> count=1, rd_valid=0; the next read returns 0x5A.
REQ-033 Write 20 bytes and read 20 bytes interleaved so the pointers wrap -> the output order matches the input order exactly; then pulse ovr_clr after an overrun -> overrun=0.
REQ-034 Assert rst asynchronously (off-edge) with count=5 -> all outputs are at reset values immediately; after release, write 0x77 and read -> rd_data=0x77.
